// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, redirect with stale-response
// drop, single held packet forwarded to decode when the bus is free.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  input  logic              bus_is_busy,
  output logic              bus_send,
  output logic [ADDR_W-1:0] bus_pkt_pc,
  output logic [INSN_W-1:0] bus_pkt_insn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] r_pkt_pc;
  logic [INSN_W-1:0] r_pkt_insn;
  logic              r_drop;
  logic              r_live;

  logic w_accept;
  logic w_send;

  // r_live keeps imem_req low until the first edge after reset release
  assign imem_req  = r_live && (r_state == S_ISSUE) && !halt;
  assign imem_addr = r_pc;
  assign w_accept  = imem_req && imem_req_ready;
  assign w_send    = (r_state == S_HOLD) && !bus_is_busy
                     && !redirect_valid;

  assign bus_send     = w_send;
  assign bus_pkt_pc   = r_pkt_pc;
  assign bus_pkt_insn = r_pkt_insn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ISSUE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_pkt_pc   <= '0;
      r_pkt_insn <= '0;
      r_drop     <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
        unique case (r_state)
          S_ISSUE: begin
            if (w_accept) begin
              r_req_pc <= r_pc;
              r_drop   <= 1'b1;
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_drop  <= 1'b0;
              r_state <= S_ISSUE;
            end else begin
              r_drop <= 1'b1;
            end
          end
          S_HOLD:  r_state <= S_ISSUE;
          default: r_state <= S_ISSUE;
        endcase
      end else begin
        unique case (r_state)
          S_ISSUE: begin
            if (w_accept) begin
              r_req_pc <= r_pc;
              r_pc     <= r_pc + STEP;
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_drop) begin
                r_drop  <= 1'b0;
                r_state <= S_ISSUE;
              end else begin
                r_pkt_pc   <= r_req_pc;
                r_pkt_insn <= imem_rsp_data;
                r_state    <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus_is_busy) r_state <= S_ISSUE;
          end
          default: r_state <= S_ISSUE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, send monitor and
// packet scoreboard driven by per-scenario tasks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        bus_is_busy;
  logic        bus_send;
  logic [31:0] bus_pkt_pc;
  logic [31:0] bus_pkt_insn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bad_sends = 0;
  int rsp_lat = 1;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_insn[$];
  int          obs_cyc[$];
  logic [31:0] exp_pc[$];

  bit          m_acc = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_paddr;
  int          m_cnt = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .bus_is_busy    (bus_is_busy),
    .bus_send       (bus_send),
    .bus_pkt_pc     (bus_pkt_pc),
    .bus_pkt_insn   (bus_pkt_insn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  always @(posedge clk) cyc++;

  // memory: accept sampled mid-cycle, response rsp_lat cycles later
  always @(negedge clk) begin
    m_acc  = rst_n && imem_req && imem_req_ready;
    m_addr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    if (m_acc) begin
      m_cnt   = rsp_lat;
      m_paddr = m_addr;
      m_acc   = 1'b0;
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(m_paddr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_send) begin
      obs_pc.push_back(bus_pkt_pc);
      obs_insn.push_back(bus_pkt_insn);
      obs_cyc.push_back(cyc);
      if (bus_is_busy) bad_sends++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget,
                          output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(negedge clk);
      #1;
      if (obs_pc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    halt           = 1'b0;
    bus_is_busy    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    rsp_lat        = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    obs_pc.delete();
    obs_insn.delete();
    obs_cyc.delete();
    exp_pc.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    halt           = 1'b0;
    bus_is_busy    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || bus_send !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl req=%b send=%b want 0 0",
               imem_req, bus_send);
    end
    checks++;
    if (bus_pkt_pc !== 32'h0 || bus_pkt_insn !== 32'h0) begin
      failures++;
      $display("FAIL reset_pkt pc=%h insn=%h want 0 0",
               bus_pkt_pc, bus_pkt_insn);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release req=%b want 0", imem_req);
    end
    step(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_first req=%b addr=%h want 1 0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h8);
    wait_obs(3, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL seq_timeout sends=%0d want 3", obs_pc.size());
    end
    halt = 1'b1;
    if (obs_cyc.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != 3) begin
          failures++;
          $display("FAIL seq_period gap=%0d want 3",
                   obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL seq_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL seq_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  task automatic test_bus_busy();
    bit ok;
    int viol;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    exp_pc.push_back(32'h8);
    wait_obs(2, 40, ok);
    step(1);
    bus_is_busy = 1'b1;
    step(2);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_send || imem_req) viol++;
      step(1);
    end
    checks++;
    if (!ok || viol != 0 || obs_pc.size() != 2) begin
      failures++;
      $display("FAIL busy_hold ok=%b viol=%0d sends=%0d want 1 0 2",
               ok, viol, obs_pc.size());
    end
    bus_is_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_send !== 1'b1 || bus_pkt_pc !== 32'h8) begin
      failures++;
      $display("FAIL busy_release send=%b pc=%h want 1 00000008",
               bus_send, bus_pkt_pc);
    end
    step(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL busy_next req=%b addr=%h want 1 0000000c",
               imem_req, imem_addr);
    end
    halt = 1'b1;
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL busy_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL busy_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    rsp_lat = 2;
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h100);
    wait_obs(1, 40, ok);
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    wait_obs(2, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rwait_timeout sends=%0d want 2", obs_pc.size());
    end
    halt = 1'b1;
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL rwait_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL rwait_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h200);
    wait_obs(1, 40, ok);
    step(1);
    bus_is_busy = 1'b1;
    step(2);
    bus_is_busy    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    checks++;
    if (bus_send !== 1'b0) begin
      failures++;
      $display("FAIL rhold_send send=%b want 0", bus_send);
    end
    step(1);
    redirect_valid = 1'b0;
    wait_obs(2, 40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rhold_timeout sends=%0d want 2", obs_pc.size());
    end
    halt = 1'b1;
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL rhold_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL rhold_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    halt = 1'b1;
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_redir req=%b addr=%h want 0 fffffffc",
               imem_req, imem_addr);
    end
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    halt = 1'b0;
    wait_obs(1, 40, ok);
    checks++;
    if (!ok || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr ok=%b addr=%h want 1 00000000",
               ok, imem_addr);
    end
    step(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_req req=%b addr=%h want 1 00000000",
               imem_req, imem_addr);
    end
    wait_obs(2, 40, ok);
    halt = 1'b1;
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL wrap_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL wrap_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  task automatic test_halt_reset();
    bit ok;
    int viol;
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;
    do_reset();
    halt = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req !== 1'b0) viol++;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL halt_req cycles_with_req=%0d want 0", viol);
    end
    step(1);
    halt = 1'b0;
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    wait_obs(2, 40, ok);
    rsp_lat = 4;
    step(2);
    imem_req_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || bus_send !== 1'b0 ||
        bus_pkt_pc !== 32'h0 || bus_pkt_insn !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset req=%b send=%b pc=%h insn=%h want 0",
               imem_req, bus_send, bus_pkt_pc, bus_pkt_insn);
    end
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL hr_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL hr_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_pc.delete();
    obs_insn.delete();
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_send) viol++;
    end
    checks++;
    if (viol != 0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL late_rsp sends=%0d req=%b addr=%h want 0 1 0",
               viol, imem_req, imem_addr);
    end
    step(1);
    rsp_lat        = 1;
    imem_req_ready = 1'b1;
    exp_pc.push_back(32'h0);
    wait_obs(1, 40, ok);
    halt = 1'b1;
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front();
      checks++;
      if (obs_pc.size() == 0) begin
        failures++;
        $display("FAIL post_reset_pkt missing, want pc=%h", e);
      end else begin
        o  = obs_pc.pop_front();
        oi = obs_insn.pop_front();
        if (o !== e || oi !== memf(e)) begin
          failures++;
          $display("FAIL post_reset_pkt pc=%h insn=%h want %h %h",
                   o, oi, e, memf(e));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bus_busy();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_halt_reset();
    checks++;
    if (bad_sends != 0) begin
      failures++;
      $display("FAIL send_while_busy count=%0d want 0", bad_sends);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
